// File: rtl/apb_s_pkg.sv
// Shared defaults and FSM state encoding for the apb_s APB slave register file.
package apb_s_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/apb_s_mem.sv
// 2**ADDR_W x DATA_W register array: one synchronous write port and an
// asynchronous read port that follows i_addr.
module apb_s_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the array is built from flops with async clear because reset must
  // zero every word immediately; a RAM macro could not offer that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/apb_s.sv
// APB slave: IDLE/SETUP/ACCESS Moore FSM in front of a small register file.
// Reads capture in SETUP->ACCESS; writes commit on the edge that leaves ACCESS.
module apb_s
  import apb_s_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              pwrite,
  output logic [DATA_W-1:0] prdata,
  output logic              pready
);

  state_e            r_state;
  logic              r_pready;
  logic [DATA_W-1:0] r_prdata;
  logic [DATA_W-1:0] w_rdata;
  logic              w_we;

  // A write commits whenever ACCESS ends with psel still high: penable=1
  // completes to IDLE, penable=0 chains straight into the next SETUP, and
  // the outgoing transfer must land in both cases.
  assign w_we = (r_state == ACCESS) && psel && pwrite;

  apb_s_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (pclk),
    .rst_n   (presetn),
    .i_we    (w_we),
    .i_addr  (paddr),
    .i_wdata (pwdata),
    .o_rdata (w_rdata)
  );

  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, so state, pready and prdata update together without ordering races.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state  <= IDLE;
      r_pready <= 1'b0;
      r_prdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_pready <= 1'b0;
          if (psel) r_state <= SETUP;
        end
        SETUP: begin
          if (!psel) begin
            r_state <= IDLE;
          end else if (penable) begin
            r_state  <= ACCESS;
            r_pready <= 1'b1;
            if (!pwrite) r_prdata <= w_rdata;
          end
        end
        ACCESS: begin
          r_pready <= 1'b0;
          r_state  <= (psel && !penable) ? SETUP : IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_pready <= 1'b0;
        end
      endcase
    end
  end

  assign pready = r_pready;
  assign prdata = r_prdata;

endmodule

// File: tb/tb_apb_s.sv
// Directed bench for apb_s: per-cycle vector table plus hand-written
// reset sequences; inputs change on negedge, outputs sampled 1 ns after posedge.
module tb_apb_s;

  logic       pclk;
  logic       presetn;
  logic [3:0] paddr;
  logic       psel;
  logic       penable;
  logic [7:0] pwdata;
  logic       pwrite;
  logic [7:0] prdata;
  logic       pready;

  int n_checks = 0;
  int n_errors = 0;

  apb_s dut (
    .pclk    (pclk),
    .presetn (presetn),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwdata  (pwdata),
    .pwrite  (pwrite),
    .prdata  (prdata),
    .pready  (pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic       psel;
    logic       pen;
    logic       pwr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       exp_rdy;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic e, logic w, logic [3:0] a,
                              logic [7:0] d, logic r, logic [7:0] q);
    vec_t v;
    v.psel = s; v.pen = e; v.pwr = w; v.addr = a; v.wdata = d;
    v.exp_rdy = r; v.exp_rd = q;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic e, input logic w,
                       input logic [3:0] a, input logic [7:0] d);
    psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
  endtask

  // One clock: drive on negedge, sample just after the following posedge.
  task automatic cycle(input logic s, input logic e, input logic w,
                       input logic [3:0] a, input logic [7:0] d,
                       input logic r, input logic [7:0] q, input string tag);
    @(negedge pclk);
    drive(s, e, w, a, d);
    @(posedge pclk);
    #1;
    check({tag, ".pready"}, {7'd0, pready}, {7'd0, r});
    check({tag, ".prdata"}, prdata, q);
  endtask

  initial begin
    presetn = 1'b0;
    drive(0, 0, 0, 4'd0, 8'd0);
    #2;
    check("reset.pready", {7'd0, pready}, 8'd0);
    check("reset.prdata", prdata, 8'd0);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;

    // Unwritten read of address 9: pready on third cycle after psel rises.
    vecs.push_back(mk(1, 0, 0, 4'd9, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 4'd9, 8'h00, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 4'd0, 8'h00, 0, 8'h00));
    // Write 220 to address 5; prdata must not move.
    vecs.push_back(mk(1, 0, 1, 4'd5, 8'd220, 0, 8'h00));
    vecs.push_back(mk(1, 1, 1, 4'd5, 8'd220, 1, 8'h00));
    vecs.push_back(mk(1, 1, 1, 4'd5, 8'd220, 0, 8'h00));
    // Read address 5 on the very next cycle.
    vecs.push_back(mk(1, 0, 0, 4'd5, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 4'd5, 8'h00, 1, 8'd220));
    vecs.push_back(mk(1, 1, 0, 4'd5, 8'h00, 0, 8'd220));
    // Back-to-back writes 0x11 @0 then 0x22 @1 via ACCESS->SETUP.
    vecs.push_back(mk(1, 0, 1, 4'd0, 8'h11, 0, 8'd220));
    vecs.push_back(mk(1, 1, 1, 4'd0, 8'h11, 1, 8'd220));
    vecs.push_back(mk(1, 0, 1, 4'd0, 8'h11, 0, 8'd220));
    vecs.push_back(mk(1, 1, 1, 4'd1, 8'h22, 1, 8'd220));
    vecs.push_back(mk(1, 1, 1, 4'd1, 8'h22, 0, 8'd220));
    // Back-to-back reads of 0 and 1.
    vecs.push_back(mk(1, 0, 0, 4'd0, 8'h00, 0, 8'd220));
    vecs.push_back(mk(1, 1, 0, 4'd0, 8'h00, 1, 8'h11));
    vecs.push_back(mk(1, 0, 0, 4'd1, 8'h00, 0, 8'h11));
    vecs.push_back(mk(1, 1, 0, 4'd1, 8'h00, 1, 8'h22));
    vecs.push_back(mk(0, 0, 0, 4'd0, 8'h00, 0, 8'h22));
    // Abort in SETUP: write 0x55 @3, psel dropped.
    vecs.push_back(mk(1, 0, 1, 4'd3, 8'h55, 0, 8'h22));
    vecs.push_back(mk(0, 0, 1, 4'd3, 8'h55, 0, 8'h22));
    vecs.push_back(mk(0, 0, 0, 4'd0, 8'h00, 0, 8'h22));
    vecs.push_back(mk(1, 0, 0, 4'd3, 8'h00, 0, 8'h22));
    vecs.push_back(mk(1, 1, 0, 4'd3, 8'h00, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 4'd0, 8'h00, 0, 8'h00));
    // Abort in ACCESS: write 0x77 @4, psel dropped on the ACCESS edge.
    vecs.push_back(mk(1, 0, 1, 4'd4, 8'h77, 0, 8'h00));
    vecs.push_back(mk(1, 1, 1, 4'd4, 8'h77, 1, 8'h00));
    vecs.push_back(mk(0, 1, 1, 4'd4, 8'h77, 0, 8'h00));
    // Read 4 with a SETUP wait state; must still be 0.
    vecs.push_back(mk(1, 0, 0, 4'd4, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 4'd4, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 1, 0, 4'd4, 8'h00, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 4'd0, 8'h00, 0, 8'h00));

    foreach (vecs[i]) begin
      cycle(vecs[i].psel, vecs[i].pen, vecs[i].pwr, vecs[i].addr, vecs[i].wdata,
            vecs[i].exp_rdy, vecs[i].exp_rd, $sformatf("vec%0d", i));
    end

    // Write 0xAA @15, read it back so prdata is non-zero before reset.
    cycle(1, 0, 1, 4'd15, 8'hAA, 0, 8'h00, "wr15.setup");
    cycle(1, 1, 1, 4'd15, 8'hAA, 1, 8'h00, "wr15.access");
    cycle(1, 1, 1, 4'd15, 8'hAA, 0, 8'h00, "wr15.done");
    cycle(1, 0, 0, 4'd15, 8'h00, 0, 8'h00, "rd15.setup");
    cycle(1, 1, 0, 4'd15, 8'h00, 1, 8'hAA, "rd15.access");
    cycle(1, 1, 0, 4'd15, 8'h00, 0, 8'hAA, "rd15.done");

    // Enter ACCESS of a write 0xBB @15, then pulse reset between edges.
    cycle(1, 0, 1, 4'd15, 8'hBB, 0, 8'hAA, "wrbb.setup");
    cycle(1, 1, 1, 4'd15, 8'hBB, 1, 8'hAA, "wrbb.access");
    #2;
    presetn = 1'b0;
    drive(0, 0, 0, 4'd0, 8'h00);
    #1;
    check("rstpulse.pready", {7'd0, pready}, 8'd0);
    check("rstpulse.prdata", prdata, 8'h00);
    #1;
    presetn = 1'b1;

    cycle(0, 0, 0, 4'd0, 8'h00, 0, 8'h00, "postrst.idle");
    cycle(1, 0, 0, 4'd15, 8'h00, 0, 8'h00, "rd15b.setup");
    cycle(1, 1, 0, 4'd15, 8'h00, 1, 8'h00, "rd15b.access");
    cycle(0, 0, 0, 4'd0, 8'h00, 0, 8'h00, "rd15b.done");

    // Address 5 was written before reset; reset must have cleared it too.
    cycle(1, 0, 0, 4'd5, 8'h00, 0, 8'h00, "rd5b.setup");
    cycle(1, 1, 0, 4'd5, 8'h00, 1, 8'h00, "rd5b.access");
    cycle(0, 0, 0, 4'd0, 8'h00, 0, 8'h00, "rd5b.done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
